// File: rtl/regfile_fwd_pkg.sv
// Shared widths, types and constants for the register file
// and its forwarding network.
package regfile_fwd_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_NUM  = 32;

  typedef logic [DATA_W-1:0] data_bus_t;
  typedef logic [ADDR_W-1:0] reg_addr_bus_t;

  localparam data_bus_t     ZERO_WORD     = 32'h0;
  localparam reg_addr_bus_t NOP_REG_ADDR  = 5'b00000;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/regfile_fwd_if.sv
// ID-stage register/bypass bus between the decoder,
// the pipeline stages and the register file.
interface regfile_fwd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic              ex_wreg_i;
  logic [ADDR_W-1:0] ex_wd_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              ex_is_load_i;
  logic              mem_wreg_i;
  logic [ADDR_W-1:0] mem_wd_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] rdata1_o;
  logic [DATA_W-1:0] rdata2_o;
  logic              stallreq_o;

  modport master (
    output we_i, waddr_i, wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    output ex_wreg_i, ex_wd_i, ex_wdata_i,
    output ex_is_load_i,
    output mem_wreg_i, mem_wd_i, mem_wdata_i,
    input  rdata1_o, rdata2_o, stallreq_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    input  ex_wreg_i, ex_wd_i, ex_wdata_i,
    input  ex_is_load_i,
    input  mem_wreg_i, mem_wd_i, mem_wdata_i,
    output rdata1_o, rdata2_o, stallreq_o
  );

endinterface

// File: rtl/regfile_fwd_port.sv
// One read port: youngest-value bypass mux and
// load-use hazard match for that port.
module regfile_fwd_port
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] rdata,
  output logic              stall
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = ex_wreg && (ex_wd == raddr);
  assign mem_hit = mem_wreg && (mem_wd == raddr);
  assign wb_hit  = we && (waddr == raddr);

  // First match wins, so overlapping items are intended.
  always_comb begin
    rdata = '0;
    priority case (1'b1)
      !rst_n:              rdata = '0;
      re != READ_ENABLE:   rdata = '0;
      raddr == '0:         rdata = '0;
      ex_hit:              rdata = ex_wdata;
      mem_hit:             rdata = mem_wdata;
      wb_hit:              rdata = wdata;
      default:             rdata = rf_data;
    endcase
  end

  assign stall = rst_n && ex_is_load && ex_wreg
              && (ex_wd != '0) && re
              && (raddr == ex_wd);

endmodule

// File: rtl/regfile_fwd.sv
// Architectural register file with EX/MEM/WB operand
// forwarding and load-use stall request for ID.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = regfile_fwd_pkg::DATA_W,
  parameter int ADDR_W   = regfile_fwd_pkg::ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic          clk_i,
  input  logic          rst_i,
  regfile_fwd_if.slave  rf
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              stall1;
  logic              stall2;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (rf.we_i == WRITE_ENABLE
              && rf.waddr_i != '0) begin
      regs[rf.waddr_i] <= rf.wdata_i;
    end
  end

  regfile_fwd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .rst_n      (rst_i),
    .re         (rf.re1_i),
    .raddr      (rf.raddr1_i),
    .ex_wreg    (rf.ex_wreg_i),
    .ex_wd      (rf.ex_wd_i),
    .ex_wdata   (rf.ex_wdata_i),
    .ex_is_load (rf.ex_is_load_i),
    .mem_wreg   (rf.mem_wreg_i),
    .mem_wd     (rf.mem_wd_i),
    .mem_wdata  (rf.mem_wdata_i),
    .we         (rf.we_i),
    .waddr      (rf.waddr_i),
    .wdata      (rf.wdata_i),
    .rf_data    (regs[rf.raddr1_i]),
    .rdata      (rf.rdata1_o),
    .stall      (stall1)
  );

  regfile_fwd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .rst_n      (rst_i),
    .re         (rf.re2_i),
    .raddr      (rf.raddr2_i),
    .ex_wreg    (rf.ex_wreg_i),
    .ex_wd      (rf.ex_wd_i),
    .ex_wdata   (rf.ex_wdata_i),
    .ex_is_load (rf.ex_is_load_i),
    .mem_wreg   (rf.mem_wreg_i),
    .mem_wd     (rf.mem_wd_i),
    .mem_wdata  (rf.mem_wdata_i),
    .we         (rf.we_i),
    .waddr      (rf.waddr_i),
    .wdata      (rf.wdata_i),
    .rf_data    (regs[rf.raddr2_i]),
    .rdata      (rf.rdata2_o),
    .stall      (stall2)
  );

  assign rf.stallreq_o = stall1 | stall2;

endmodule

// File: tb/tb_regfile_fwd.sv
// Bench for regfile_fwd: directed cases plus random
// traffic checked every cycle against a register model.
module tb_regfile_fwd;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  regfile_fwd_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  regfile_fwd dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rf    (rf)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [32];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(
    input logic re, input logic [4:0] ra);
    if (!rst_i || !re || ra == 5'd0) return 32'h0;
    if (rf.ex_wreg_i && rf.ex_wd_i == ra)
      return rf.ex_wdata_i;
    if (rf.mem_wreg_i && rf.mem_wd_i == ra)
      return rf.mem_wdata_i;
    if (rf.we_i && rf.waddr_i == ra)
      return rf.wdata_i;
    return model[ra];
  endfunction

  function automatic logic port_hazard(
    input logic re, input logic [4:0] ra);
    return rst_i && rf.ex_is_load_i && rf.ex_wreg_i
        && rf.ex_wd_i != 5'd0 && re && ra == rf.ex_wd_i;
  endfunction

  // Architectural state as seen after each edge.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (rf.we_i && rf.waddr_i != 5'd0) begin
      model[rf.waddr_i] = rf.wdata_i;
    end
  end

  always @(negedge clk_i) begin
    logic h1;
    logic h2;
    h1 = port_hazard(rf.re1_i, rf.raddr1_i);
    h2 = port_hazard(rf.re2_i, rf.raddr2_i);
    check("stall", {31'h0, rf.stallreq_o},
          {31'h0, h1 | h2});
    if (!h1)
      check("rdata1", rf.rdata1_o,
            ref_read(rf.re1_i, rf.raddr1_i));
    if (!h2)
      check("rdata2", rf.rdata2_o,
            ref_read(rf.re2_i, rf.raddr2_i));
  end

  task automatic idle();
    rf.we_i = 0; rf.waddr_i = 0; rf.wdata_i = 0;
    rf.re1_i = 0; rf.raddr1_i = 0;
    rf.re2_i = 0; rf.raddr2_i = 0;
    rf.ex_wreg_i = 0; rf.ex_wd_i = 0;
    rf.ex_wdata_i = 0; rf.ex_is_load_i = 0;
    rf.mem_wreg_i = 0; rf.mem_wd_i = 0;
    rf.mem_wdata_i = 0;
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    idle();
    rst_i = 0;
    rf.we_i = 1; rf.waddr_i = 5;
    rf.wdata_i = 32'hFFFF_FFFF;
    rf.re1_i = 1; rf.raddr1_i = 5;
    #2;
    check("rst_rdata1", rf.rdata1_o, 32'h0);
    check("rst_stall", {31'h0, rf.stallreq_o}, 32'h0);
    next();
    next();
    check("rst_rdata1_b", rf.rdata1_o, 32'h0);
    rst_i = 1;
    rf.we_i = 0;
    #1;
    check("rd5_after_rst", rf.rdata1_o, 32'h0);

    next();
    idle();
    rf.we_i = 1; rf.waddr_i = 3; rf.wdata_i = 32'h7;
    next();
    idle();
    rf.re1_i = 1; rf.raddr1_i = 3;
    #1;
    check("rd3", rf.rdata1_o, 32'h7);

    rf.we_i = 1; rf.waddr_i = 0; rf.wdata_i = 32'h1234;
    rf.re2_i = 1; rf.raddr2_i = 0;
    #1;
    check("rd0_wt", rf.rdata2_o, 32'h0);
    next();
    idle();
    rf.re2_i = 1; rf.raddr2_i = 0;
    #1;
    check("rd0", rf.rdata2_o, 32'h0);

    rf.we_i = 1; rf.waddr_i = 9; rf.wdata_i = 32'h18;
    rf.re2_i = 1; rf.raddr2_i = 9;
    #1;
    check("wr_through", rf.rdata2_o, 32'h18);

    next();
    idle();
    rf.we_i = 1; rf.waddr_i = 4; rf.wdata_i = 32'h1;
    next();
    rf.wdata_i = 32'h2;
    rf.mem_wreg_i = 1; rf.mem_wd_i = 4;
    rf.mem_wdata_i = 32'h3;
    rf.ex_wreg_i = 1; rf.ex_wd_i = 4;
    rf.ex_wdata_i = 32'h1F;
    rf.re1_i = 1; rf.raddr1_i = 4;
    #1;
    check("prio_ex", rf.rdata1_o, 32'h1F);
    rf.ex_wreg_i = 0;
    #1;
    check("prio_mem", rf.rdata1_o, 32'h3);
    rf.mem_wreg_i = 0;
    #1;
    check("prio_wb", rf.rdata1_o, 32'h2);
    next();
    idle();
    rf.re1_i = 1; rf.raddr1_i = 4;
    #1;
    check("prio_arr", rf.rdata1_o, 32'h2);

    rf.ex_is_load_i = 1; rf.ex_wreg_i = 1;
    rf.ex_wd_i = 7;
    rf.re2_i = 1; rf.raddr2_i = 7;
    #1;
    check("lu_stall", {31'h0, rf.stallreq_o}, 32'h1);
    rf.re2_i = 0;
    #1;
    check("lu_re0", {31'h0, rf.stallreq_o}, 32'h0);
    rf.re2_i = 1; rf.ex_wd_i = 0; rf.raddr2_i = 0;
    #1;
    check("lu_wd0", {31'h0, rf.stallreq_o}, 32'h0);

    next();
    idle();
    rf.re1_i = 1; rf.raddr1_i = 12;
    rf.re2_i = 1; rf.raddr2_i = 12;
    rf.mem_wreg_i = 1; rf.mem_wd_i = 12;
    rf.mem_wdata_i = 32'hABCD;
    #1;
    check("dual1", rf.rdata1_o, 32'hABCD);
    check("dual2", rf.rdata2_o, 32'hABCD);

    for (int c = 0; c < 3000; c++) begin
      next();
      rst_i = ($urandom_range(0, 59) != 0);
      rf.we_i = $urandom_range(0, 1);
      rf.waddr_i = 5'($urandom_range(0, 7));
      rf.wdata_i = $urandom;
      rf.re1_i = ($urandom_range(0, 7) != 0);
      rf.raddr1_i = 5'($urandom_range(0, 7));
      rf.re2_i = ($urandom_range(0, 7) != 0);
      rf.raddr2_i = ($urandom_range(0, 9) == 0)
                  ? 5'($urandom) : 5'($urandom_range(0, 7));
      rf.ex_wreg_i = ($urandom_range(0, 2) == 0);
      rf.ex_wd_i = 5'($urandom_range(0, 7));
      rf.ex_wdata_i = $urandom;
      rf.ex_is_load_i = ($urandom_range(0, 2) == 0);
      rf.mem_wreg_i = ($urandom_range(0, 2) == 0);
      rf.mem_wd_i = 5'($urandom_range(0, 7));
      rf.mem_wdata_i = $urandom;
    end

    next();
    rst_i = 1;
    idle();
    next();
    @(negedge clk_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
